// File: rtl/wdg_pkg.sv
// Shared types and constants for the watchdog reset/NMI controller.
//   rst_state_e : controller FSM states
//   CAUSE_*     : bit positions inside the sticky reset-cause register
//   cause_bit() : one-hot cause value for a given bit position
package wdg_pkg;

  localparam int unsigned CAUSE_W = 4;
  localparam int unsigned CNT_W   = 8;

  localparam int unsigned CAUSE_POR = 0;
  localparam int unsigned CAUSE_WDG = 1;
  localparam int unsigned CAUSE_EXT = 2;
  localparam int unsigned CAUSE_SW  = 3;

  typedef enum logic [1:0] {
    RST_RUN    = 2'd0,
    RST_HOLD   = 2'd1,
    RST_SETTLE = 2'd2
  } rst_state_e;

  function automatic logic [CAUSE_W-1:0] cause_bit(input int unsigned idx);
    return CAUSE_W'(1) << idx;
  endfunction

endpackage

// File: rtl/wdg_reset_ctrl_if.sv
// Request/status bundle between the SoC and the reset controller.
//   master : request sources (watchdog, NMI, external, software, clear/ack)
//   slave  : the reset controller, producing reset, done, cause and NMI status
interface wdg_reset_ctrl_if
  import wdg_pkg::*;
#(
  parameter int unsigned NMI_CNT_W = 8
);

  logic                 reset_wdg_n;
  logic                 nmi;
  logic                 ext_rst_req;
  logic                 sw_rst_req;
  logic                 cause_clr;
  logic                 nmi_ack;
  logic                 sys_rst;
  logic                 rst_done;
  logic [CAUSE_W-1:0]   rst_cause;
  logic                 nmi_irq;
  logic [NMI_CNT_W-1:0] nmi_cnt;
  logic [CNT_W-1:0]     wdg_rst_cnt;

  modport master (
    output reset_wdg_n, nmi, ext_rst_req, sw_rst_req, cause_clr, nmi_ack,
    input  sys_rst, rst_done, rst_cause, nmi_irq, nmi_cnt, wdg_rst_cnt
  );

  modport slave (
    input  reset_wdg_n, nmi, ext_rst_req, sw_rst_req, cause_clr, nmi_ack,
    output sys_rst, rst_done, rst_cause, nmi_irq, nmi_cnt, wdg_rst_cnt
  );

endinterface

// File: rtl/wdg_edge_det.sv
// Single-edge detector with configurable polarity and history reset value.
//   clk, reset : clock, synchronous active-high reset
//   din        : level to watch
//   edge_c     : combinational one-cycle strobe (rising, or falling if FALL=1)
module wdg_edge_det #(
  parameter bit FALL    = 1'b0,
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic edge_c
);

  logic q;

  always_ff @(posedge clk) begin
    if (reset) q <= RST_VAL;
    else       q <= din;
  end

  assign edge_c = FALL ? (q & ~din) : (din & ~q);

endmodule

// File: rtl/wdg_reset_ctrl.sv
// Reset/NMI controller downstream of the watchdog: stretches reset requests
// into sys_rst, adds a settle window before rst_done, records the reset cause
// and latches/counts NMI events.
//   clk, reset : clock, synchronous active-high power-on reset
//   bus        : wdg_reset_ctrl_if.slave (requests in, reset/status out)
// Optional macro WDG_RST_CNT_EN builds the saturating watchdog-reset counter;
// without it wdg_rst_cnt is tied to zero.
module wdg_reset_ctrl
  import wdg_pkg::*;
#(
  parameter int unsigned HOLD_CYC   = 16,
  parameter int unsigned SETTLE_CYC = 8,
  parameter int unsigned NMI_CNT_W  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  wdg_reset_ctrl_if.slave        bus
);

  rst_state_e           state;
  logic [CNT_W-1:0]     cnt;
  logic                 sys_rst;
  logic                 rst_done;
  logic [CAUSE_W-1:0]   rst_cause;
  logic                 nmi_irq;
  logic [NMI_CNT_W-1:0] nmi_cnt;

  logic                 wdg_e;
  logic                 nmi_e;
  logic [CAUSE_W-1:0]   req_src_c;
  logic                 req_c;
  logic                 nmi_acc_c;
  logic                 enter_hold_c;

  // A held-low watchdog request counts once, so only its falling edge matters.
  wdg_edge_det #(.FALL(1'b1), .RST_VAL(1'b1)) u_wdg_edge (
    .clk    (clk),
    .reset  (reset),
    .din    (bus.reset_wdg_n),
    .edge_c (wdg_e)
  );

  wdg_edge_det #(.FALL(1'b0), .RST_VAL(1'b0)) u_nmi_edge (
    .clk    (clk),
    .reset  (reset),
    .din    (bus.nmi),
    .edge_c (nmi_e)
  );

  // Request sources of this cycle, placed at their cause-register positions.
  always_comb begin
    req_src_c            = '0;
    req_src_c[CAUSE_WDG] = wdg_e;
    req_src_c[CAUSE_EXT] = bus.ext_rst_req;
    req_src_c[CAUSE_SW]  = bus.sw_rst_req;
  end

  assign req_c        = |req_src_c;
  assign nmi_acc_c    = nmi_e & ~sys_rst;
  assign enter_hold_c = req_c & (state != RST_HOLD);

  // Reset sequencing FSM with registered (Moore) outputs and cause tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RST_HOLD;
      cnt       <= '0;
      sys_rst   <= 1'b1;
      rst_done  <= 1'b0;
      rst_cause <= cause_bit(CAUSE_POR);
    end else begin
      case (state)
        RST_HOLD: begin
          if (req_c) begin
            cnt       <= '0;
            rst_cause <= rst_cause | req_src_c;
          end else if (cnt == CNT_W'(HOLD_CYC - 1)) begin
            state   <= RST_SETTLE;
            cnt     <= '0;
            sys_rst <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RST_SETTLE: begin
          if (req_c) begin
            state     <= RST_HOLD;
            cnt       <= '0;
            sys_rst   <= 1'b1;
            rst_cause <= rst_cause | req_src_c;
          end else if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
            state    <= RST_RUN;
            cnt      <= '0;
            rst_done <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RST_RUN: begin
          // A new reset replaces the cause history, dropping the POR bit.
          if (req_c) begin
            state     <= RST_HOLD;
            cnt       <= '0;
            sys_rst   <= 1'b1;
            rst_done  <= 1'b0;
            rst_cause <= req_src_c;
          end else if (bus.cause_clr) begin
            rst_cause <= '0;
          end
        end
        default: begin
          state    <= RST_HOLD;
          cnt      <= '0;
          sys_rst  <= 1'b1;
          rst_done <= 1'b0;
        end
      endcase
    end
  end

  // NMI flag and saturating event counter; edges are ignored while in reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      nmi_irq <= 1'b0;
      nmi_cnt <= '0;
    end else begin
      if (enter_hold_c)        nmi_irq <= 1'b0;
      else if (nmi_acc_c)      nmi_irq <= 1'b1;
      else if (bus.nmi_ack)    nmi_irq <= 1'b0;
      if (nmi_acc_c && !(&nmi_cnt)) nmi_cnt <= nmi_cnt + NMI_CNT_W'(1);
    end
  end

`ifdef WDG_RST_CNT_EN
  logic [CNT_W-1:0] wdg_rst_cnt;

  // Counts every watchdog request edge, regardless of controller state.
  always_ff @(posedge clk) begin
    if (reset)                         wdg_rst_cnt <= '0;
    else if (wdg_e && !(&wdg_rst_cnt)) wdg_rst_cnt <= wdg_rst_cnt + CNT_W'(1);
  end

  assign bus.wdg_rst_cnt = wdg_rst_cnt;
`else
  assign bus.wdg_rst_cnt = '0;
`endif

  assign bus.sys_rst   = sys_rst;
  assign bus.rst_done  = rst_done;
  assign bus.rst_cause = rst_cause;
  assign bus.nmi_irq   = nmi_irq;
  assign bus.nmi_cnt   = nmi_cnt;

endmodule

// File: tb/tb_wdg_reset_ctrl.sv
// Self-checking bench for wdg_reset_ctrl: directed scenarios with literal
// expectations followed by randomized stimulus, all checked every cycle
// against a distance-from-last-request model of the reset sequence.
module tb_wdg_reset_ctrl;

  localparam int unsigned HOLD   = 16;
  localparam int unsigned SETTLE = 8;
  localparam int unsigned NW     = 8;

  logic clk;
  logic reset;

  wdg_reset_ctrl_if #(.NMI_CNT_W(NW)) bus ();

  wdg_reset_ctrl #(
    .HOLD_CYC   (HOLD),
    .SETTLE_CYC (SETTLE),
    .NMI_CNT_W  (NW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: everything about the reset sequence follows from the number of
  // clock edges since the most recent request (power-on reset counts as one).
  int         since;
  logic [3:0] m_cause;
  logic       m_irq;
  int         m_ncnt;
  int         m_wcnt;
  logic       prev_wdg;
  logic       prev_nmi;

  always @(posedge clk) begin
    logic       was_run;
    logic       was_rst;
    logic       wdg_e;
    logic       nmi_e;
    logic       acc;
    logic [3:0] src;
    if (reset) begin
      since    = 0;
      m_cause  = 4'b0001;
      m_irq    = 1'b0;
      m_ncnt   = 0;
      m_wcnt   = 0;
      prev_wdg = 1'b1;
      prev_nmi = 1'b0;
    end else begin
      was_run = (since >= int'(HOLD + SETTLE));
      was_rst = (since < int'(HOLD));
      wdg_e   = prev_wdg && !bus.reset_wdg_n;
      nmi_e   = bus.nmi && !prev_nmi;
      src     = {bus.sw_rst_req, bus.ext_rst_req, wdg_e, 1'b0};
      acc     = nmi_e && !was_rst;
      if (src != 4'b0000) m_cause = was_run ? src : (m_cause | src);
      else if (was_run && bus.cause_clr) m_cause = 4'b0000;
      if (acc && m_ncnt < (1 << NW) - 1) m_ncnt++;
      if (src != 4'b0000) m_irq = 1'b0;
      else if (acc)       m_irq = 1'b1;
      else if (bus.nmi_ack) m_irq = 1'b0;
`ifdef WDG_RST_CNT_EN
      if (wdg_e && m_wcnt < 255) m_wcnt++;
`endif
      if (src != 4'b0000) since = 0;
      else if (since < 100000) since++;
      prev_wdg = bus.reset_wdg_n;
      prev_nmi = bus.nmi;
    end
  end

  // Compare process: outputs settle shortly after each rising edge.
  always @(posedge clk) begin
    #1;
    check("sys_rst",     bus.sys_rst,     (since < int'(HOLD)) ? 1 : 0);
    check("rst_done",    bus.rst_done,    (since >= int'(HOLD + SETTLE)) ? 1 : 0);
    check("rst_cause",   bus.rst_cause,   m_cause);
    check("nmi_irq",     bus.nmi_irq,     m_irq);
    check("nmi_cnt",     bus.nmi_cnt,     m_ncnt);
    check("wdg_rst_cnt", bus.wdg_rst_cnt, m_wcnt);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  int exp_wcnt;

  initial begin
`ifdef WDG_RST_CNT_EN
    exp_wcnt = 1;
`else
    exp_wcnt = 0;
`endif
    reset           = 1'b1;
    bus.reset_wdg_n = 1'b1;
    bus.nmi         = 1'b0;
    bus.ext_rst_req = 1'b0;
    bus.sw_rst_req  = 1'b0;
    bus.cause_clr   = 1'b0;
    bus.nmi_ack     = 1'b0;

    // Power-on sequence.
    tick(3);
    check("por_sys_rst", bus.sys_rst, 1);
    check("por_cause", bus.rst_cause, 4'b0001);
    check("por_nmi_cnt", bus.nmi_cnt, 0);
    reset = 1'b0;
    tick(15);
    check("por_hold_last", bus.sys_rst, 1);
    tick(1);
    check("por_settle_rst", bus.sys_rst, 0);
    check("por_settle_done", bus.rst_done, 0);
    tick(7);
    check("por_settle_last", bus.rst_done, 0);
    tick(1);
    check("por_done", bus.rst_done, 1);
    check("por_cause_run", bus.rst_cause, 4'b0001);

    // External request during SETTLE.
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(18);
    bus.ext_rst_req = 1'b1;
    tick(40);
    bus.ext_rst_req = 1'b0;
    check("ext_held_rst", bus.sys_rst, 1);
    tick(15);
    check("ext_hold_last", bus.sys_rst, 1);
    tick(1);
    check("ext_released", bus.sys_rst, 0);
    check("ext_cause", bus.rst_cause, 4'b0101);
    tick(30);

    // Watchdog request held low for 256 cycles.
    bus.reset_wdg_n = 1'b0;
    tick(1);
    check("wdg_rst", bus.sys_rst, 1);
    check("wdg_cause", bus.rst_cause, 4'b0010);
    check("wdg_cnt", bus.wdg_rst_cnt, exp_wcnt);
    tick(15);
    check("wdg_hold_last", bus.sys_rst, 1);
    tick(1);
    check("wdg_hold_end", bus.sys_rst, 0);
    tick(239);
    check("wdg_single_entry", bus.rst_done, 1);
    check("wdg_cnt_final", bus.wdg_rst_cnt, exp_wcnt);
    bus.reset_wdg_n = 1'b1;
    tick(1);

    // Software request coinciding with cause_clr, then clear rules.
    bus.sw_rst_req = 1'b1;
    bus.cause_clr  = 1'b1;
    tick(1);
    bus.sw_rst_req = 1'b0;
    bus.cause_clr  = 1'b0;
    check("sw_cause", bus.rst_cause, 4'b1000);
    check("sw_rst", bus.sys_rst, 1);
    tick(3);
    bus.cause_clr = 1'b1;
    tick(1);
    bus.cause_clr = 1'b0;
    check("clr_in_hold", bus.rst_cause, 4'b1000);
    tick(30);
    bus.cause_clr = 1'b1;
    tick(1);
    bus.cause_clr = 1'b0;
    check("clr_in_run", bus.rst_cause, 4'b0000);

    // NMI edge while in reset is ignored.
    bus.sw_rst_req = 1'b1;
    tick(1);
    bus.sw_rst_req = 1'b0;
    tick(2);
    bus.nmi = 1'b1;
    tick(1);
    bus.nmi = 1'b0;
    check("nmi_in_rst_irq", bus.nmi_irq, 0);
    check("nmi_in_rst_cnt", bus.nmi_cnt, 0);
    tick(30);

    // NMI saturation and ack/edge coincidence.
    for (int i = 0; i < 300; i++) begin
      bus.nmi = 1'b1;
      tick(1);
      bus.nmi = 1'b0;
      tick(1);
    end
    check("nmi_sat", bus.nmi_cnt, 255);
    check("nmi_irq_set", bus.nmi_irq, 1);
    bus.nmi     = 1'b1;
    bus.nmi_ack = 1'b1;
    tick(1);
    bus.nmi     = 1'b0;
    check("nmi_ack_vs_edge", bus.nmi_irq, 1);
    tick(1);
    bus.nmi_ack = 1'b0;
    check("nmi_ack_clears", bus.nmi_irq, 0);

    // Randomized traffic checked by the model.
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 39) == 0) bus.reset_wdg_n = ~bus.reset_wdg_n;
      if (bus.ext_rst_req) bus.ext_rst_req = ($urandom_range(0, 9) != 0);
      else                 bus.ext_rst_req = ($urandom_range(0, 299) == 0);
      bus.sw_rst_req = ($urandom_range(0, 149) == 0);
      bus.cause_clr  = ($urandom_range(0, 14) == 0);
      if ($urandom_range(0, 2) == 0) bus.nmi = ~bus.nmi;
      bus.nmi_ack    = ($urandom_range(0, 5) == 0);
      tick(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
